siso_io_retimer: RTL

//  Parametrised I/O retiming shell between layer-memory/control fabric and a SISO row unit core.

---
 rtl/siso_pkg.sv | 15 +
 rtl/siso_pipe_chain.sv | 49 ++++
 rtl/siso_io_retimer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/siso_pkg.sv
// Shared defaults and the flush-handshake state type for the SISO I/O retimer.
package siso_pkg;

  localparam int WC_DEFAULT        = 32;
  localparam int W_DEFAULT         = 6;
  localparam int ADDRWIDTH_DEFAULT = 5;
  localparam int LLRVEC_W          = WC_DEFAULT * W_DEFAULT;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/siso_pipe_chain.sv
// Register chain of DEPTH stages with a shared hold, a valid mask applied on entry
// and an OR of every valid bit held anywhere in the chain.
module siso_pipe_chain #(
  parameter int DW    = 8,
  parameter int VW    = 1,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic [VW-1:0] vmask,
  input  logic [DW-1:0] din,
  input  logic [VW-1:0] vin,
  output logic [DW-1:0] dout,
  output logic [VW-1:0] vout,
  output logic          any_valid
);

  logic [DW-1:0] data_q  [DEPTH];
  logic [VW-1:0] valid_q [DEPTH];

  // Payload is captured unmasked; only the valid bits are gated at stage 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        valid_q[i] <= '0;
      end
    end else if (!hold) begin
      data_q[0]  <= din;
      valid_q[0] <= vin & vmask;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | (|valid_q[i]);
    end
  end

  assign dout = data_q[DEPTH-1];
  assign vout = valid_q[DEPTH-1];

endmodule

// File: rtl/siso_io_retimer.sv
// Configurable-depth I/O retiming shell around a SISO row unit core, with stall,
// drain/flush handshake and idle flag. Define SISO_IORT_CNT_EN for the event counters.
module siso_io_retimer
  import siso_pkg::*;
#(
  parameter int WC         = WC_DEFAULT,
  parameter int W          = W_DEFAULT,
  parameter int ADDRWIDTH  = ADDRWIDTH_DEFAULT,
  parameter int IN_STAGES  = 1,
  parameter int OUT_STAGES = 1,
  parameter int CNTW       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   h_rdlayer,
  input  logic [ADDRWIDTH-1:0]   h_rdaddr,
  input  logic                   h_rden_llr,
  input  logic                   h_rden_e,
  input  logic [WC*W-1:0]        h_lmem,
  input  logic [WC*W-1:0]        h_dreacc,
  output logic                   c_rdlayer,
  output logic [ADDRWIDTH-1:0]   c_rdaddr,
  output logic                   c_rden_llr,
  output logic                   c_rden_e,
  output logic [WC*W-1:0]        c_lmem,
  output logic [WC*W-1:0]        c_dreacc,
  input  logic [WC*W-1:0]        c_updllr,
  input  logic [WC*W-1:0]        c_dout,
  input  logic                   c_wrlayer,
  input  logic [ADDRWIDTH-1:0]   c_wraddr,
  input  logic                   c_wren,
  input  logic [ADDRWIDTH+1:0]   c_dmem_rla,
  output logic [WC*W-1:0]        h_updllr,
  output logic [WC*W-1:0]        h_dout,
  output logic                   h_wrlayer,
  output logic [ADDRWIDTH-1:0]   h_wraddr,
  output logic                   h_wren,
  output logic [ADDRWIDTH+1:0]   h_dmem_rla,
  input  logic                   stall,
  input  logic                   flush_req,
  output logic                   flush_ack,
  output logic                   idle,
  output logic [CNTW-1:0]        rd_cnt,
  output logic [CNTW-1:0]        wr_cnt
);

  localparam int LW    = WC * W;
  localparam int HC_DW = 1 + ADDRWIDTH + 2 * LW;
  localparam int CH_DW = 2 * LW + 1 + ADDRWIDTH + ADDRWIDTH + 1;

  if (IN_STAGES < 1 || IN_STAGES > 4) begin : g_bad_in_stages
    $error("siso_io_retimer: IN_STAGES must be in 1..4");
  end
  if (OUT_STAGES < 1 || OUT_STAGES > 4) begin : g_bad_out_stages
    $error("siso_io_retimer: OUT_STAGES must be in 1..4");
  end

  state_t state, state_next;
  logic [1:0]       rd_mask;
  logic             in_any, out_any;
  logic [HC_DW-1:0] hc_dout;
  logic [1:0]       hc_vout;
  logic [CH_DW-1:0] ch_dout;
  logic [1:0]       ch_vout;

  siso_pipe_chain #(.DW(HC_DW), .VW(2), .DEPTH(IN_STAGES)) u_host_to_core (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .vmask     (rd_mask),
    .din       ({h_rdlayer, h_rdaddr, h_lmem, h_dreacc}),
    .vin       ({h_rden_llr, h_rden_e}),
    .dout      (hc_dout),
    .vout      (hc_vout),
    .any_valid (in_any)
  );

  assign {c_rdlayer, c_rdaddr, c_lmem, c_dreacc} = hc_dout;
  assign {c_rden_llr, c_rden_e}                  = hc_vout;

  // The D-mem read valid travels as a valid lane; its layer/address bits ride as payload.
  siso_pipe_chain #(.DW(CH_DW), .VW(2), .DEPTH(OUT_STAGES)) u_core_to_host (
    .clk       (clk),
    .rst       (rst),
    .hold      (stall),
    .vmask     (2'b11),
    .din       ({c_updllr, c_dout, c_wrlayer, c_wraddr, c_dmem_rla[ADDRWIDTH:0]}),
    .vin       ({c_wren, c_dmem_rla[ADDRWIDTH+1]}),
    .dout      (ch_dout),
    .vout      (ch_vout),
    .any_valid (out_any)
  );

  assign {h_updllr, h_dout, h_wrlayer, h_wraddr} = ch_dout[CH_DW-1:ADDRWIDTH+1];
  assign h_wren     = ch_vout[1];
  assign h_dmem_rla = {ch_vout[0], ch_dout[ADDRWIDTH:0]};

  assign idle = !(in_any || out_any);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Drain completes once nothing is in flight and the core is not issuing anything new.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_req && !stall) state_next = DRAIN;
      DRAIN:   if (!in_any && !out_any && !c_wren && !c_dmem_rla[ADDRWIDTH+1]) state_next = ACK;
      ACK:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    flush_ack = (state == ACK);
    rd_mask   = (state == DRAIN) ? 2'b00 : 2'b11;
  end

`ifdef SISO_IORT_CNT_EN
  logic [CNTW-1:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (!stall) begin
      if ((c_rden_llr || c_rden_e) && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + CNTW'(1);
      if (h_wren && (wr_cnt_q != '1))                   wr_cnt_q <= wr_cnt_q + CNTW'(1);
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = '0;
  assign wr_cnt = '0;
`endif

endmodule
